// File: rtl/mem_pkg.sv
// Shared definitions for the multi-channel word memory controller:
// FSM state codes, default geometry, channel indices and an address check.
package mem_pkg;

    localparam int DW_DEF    = 31;
    localparam int AW_DEF    = 12;
    localparam int DEPTH_DEF = 2048;
    localparam int N_DEF     = 4;

    // Conventional channel assignment of the machine units
    localparam int CH_PU  = 0;
    localparam int CH_PNL = 1;
    localparam int CH_IO  = 2;
    localparam int CH_AC  = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACCESS  = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_REPLY   = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_CLEAR   = 3'd5;

    // Unsigned full-width range check; no wrap-around of addresses
    function automatic logic addr_ok(input logic [31:0] addr, input int depth);
        return (addr < 32'(depth));
    endfunction

endpackage

// File: rtl/mem_arb.sv
// N-way request arbiter: fixed priority (lowest index) or round-robin
// starting at the pointer supplied by the parent. Purely combinational.
module mem_arb
    import mem_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RR = 0,
    parameter int NW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [NW-1:0] idx
);

    logic found_s;

    // Candidate channel for search position off
    function automatic int cand(input logic [NW-1:0] p, input int off);
        if (RR != 0) begin
            return (int'(p) + off) % N;
        end else begin
            return off;
        end
    endfunction

    // Scan channels in priority order and grant the first active one
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!found_s && req[cand(ptr, off)]) begin
                found_s                = 1'b1;
                grant[cand(ptr, off)]  = 1'b1;
                idx                    = NW'(cand(ptr, off));
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-channel word memory controller: arbitrates N requesters onto one
// synchronous RAM with req/reply handshakes, range checking and a bulk
// zero-fill sweep triggered from the panel.
module mem_ctrl_arb
    import mem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int N     = N_DEF,
    parameter int RR    = 0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N-1:0]    req_read,
    input  logic [N-1:0]    req_write,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    reply,
    output logic            reply_err,
    output logic [DW-1:0]   rdata,
    input  logic            clear_start,
    output logic            clear_busy
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [2:0]    state_q, state_d;
    logic [NW-1:0] win_q, win_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          ram_we_q, ram_we_d;
    logic          ram_re_q, ram_re_d;
    logic [IW-1:0] clr_cnt_q, clr_cnt_d;
    logic [NW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  reply_q, reply_d;
    logic          reply_err_q, reply_err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          clear_busy_q, clear_busy_d;

    logic [N-1:0]  req_any_s, grant_s;
    logic [NW-1:0] idx_s;
    logic          in_range_s;
    logic          mem_we_s;
    logic [IW-1:0] mem_waddr_s;
    logic [DW-1:0] mem_wdata_s;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [DEPTH];

    assign req_any_s  = req_read | req_write;
    assign in_range_s = addr_ok(32'(addr_q), DEPTH);

    mem_arb #(.N(N), .RR(RR), .NW(NW)) u_arb (
        .req   (req_any_s),
        .ptr   (ptr_q),
        .grant (grant_s),
        .idx   (idx_s)
    );

    // Next-state and datapath logic of the transaction sequencer
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        ram_we_d     = 1'b0;
        ram_re_d     = 1'b0;
        clr_cnt_d    = clr_cnt_q;
        ptr_d        = ptr_q;
        reply_d      = '0;
        reply_err_d  = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    clr_cnt_d = '0;
                    state_d   = ST_CLEAR;
                end else if (|req_any_s) begin
                    win_d   = idx_s;
                    // a write wins over a read held on the same channel
                    wr_d    = |(grant_s & req_write);
                    addr_d  = req_addr[int'(idx_s)*AW +: AW];
                    wdata_d = req_wdata[int'(idx_s)*DW +: DW];
                    if (RR != 0) begin
                        ptr_d = NW'((int'(idx_s) + 1) % N);
                    end else begin
                        ptr_d = ptr_q;
                    end
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                err_d    = !in_range_s;
                ram_we_d = wr_q && in_range_s;
                ram_re_d = !wr_q && in_range_s;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_REPLY;
            end
            ST_REPLY: begin
                reply_d[win_q] = 1'b1;
                reply_err_d    = err_q;
                if (!wr_q) begin
                    if (err_q) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = ram_q;
                    end
                end else begin
                    rdata_d = rdata_q;
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // hold off until the served channel withdraws its request
                if (!req_read[win_q] && !req_write[win_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        clear_busy_d = (state_d == ST_CLEAR);
    end

    // RAM write port: sweep writes zeros, otherwise the registered access
    always_comb begin
        if (state_q == ST_CLEAR) begin
            mem_we_s    = resetn;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = resetn && ram_we_q;
            mem_waddr_s = addr_q[IW-1:0];
            mem_wdata_s = wdata_q;
        end
    end

    // Inferred single-port RAM with synchronous read, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
        if (ram_re_q) begin
            ram_q <= mem[addr_q[IW-1:0]];
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
            clr_cnt_q    <= '0;
            ptr_q        <= '0;
            reply_q      <= '0;
            reply_err_q  <= 1'b0;
            rdata_q      <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            ram_we_q     <= ram_we_d;
            ram_re_q     <= ram_re_d;
            clr_cnt_q    <= clr_cnt_d;
            ptr_q        <= ptr_d;
            reply_q      <= reply_d;
            reply_err_q  <= reply_err_d;
            rdata_q      <= rdata_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    assign reply      = reply_q;
    assign reply_err  = reply_err_q;
    assign rdata      = rdata_q;
    assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Scoreboard bench for mem_ctrl_arb: a fixed-priority instance exercised with
// directed and random traffic against a word-array model, plus a round-robin
// instance checked for grant order.
module tb_mem_ctrl_arb;

    localparam int DW = 31, AW = 12, DEPTH = 2048, N = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_read, req_write, reply;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            reply_err, clear_start, clear_busy;
    logic [DW-1:0]   rdata;

    logic [N-1:0]    b_req_read, b_req_write, b_reply;
    logic [N*AW-1:0] b_req_addr;
    logic [N*DW-1:0] b_req_wdata;
    logic            b_reply_err, b_clear_start, b_clear_busy;
    logic [DW-1:0]   b_rdata;

    always #5 clk = ~clk;

    mem_ctrl_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .N(N), .RR(0)) u_dut (
        .clk(clk), .resetn(resetn), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .reply(reply),
        .reply_err(reply_err), .rdata(rdata), .clear_start(clear_start),
        .clear_busy(clear_busy));

    mem_ctrl_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .N(N), .RR(1)) u_rr (
        .clk(clk), .resetn(resetn), .req_read(b_req_read), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .reply(b_reply),
        .reply_err(b_reply_err), .rdata(b_rdata), .clear_start(b_clear_start),
        .clear_busy(b_clear_busy));

    typedef struct {
        int            ch;
        bit            err;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          exp_q[$];
    int            b_exp_q[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rd;
    int            checks = 0, errors = 0;
    int            cyc = 0;
    int            busy_cnt = 0, last_busy_cyc = 0;
    exp_t          m_e;
    int            m_b;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clear_busy) begin
            busy_cnt      = busy_cnt + 1;
            last_busy_cyc = cyc;
        end
    end

    function automatic logic [N-1:0] onehot(input int ch);
        logic [N-1:0] r;
        r     = '0;
        r[ch] = 1'b1;
        return r;
    endfunction

    // Expected reply for a request, pushed in the order it will be served
    function automatic void push_exp(input int ch, input bit wr, input int addr,
                                     input logic [DW-1:0] d);
        exp_t e;
        e.ch  = ch;
        e.err = (addr >= DEPTH);
        if (wr && !e.err) model[addr] = d;
        if (!wr) last_rd = e.err ? '0 : model[addr];
        e.rd = last_rd;
        exp_q.push_back(e);
    endfunction

    // Monitor for the fixed-priority instance
    always @(negedge clk) begin
        if (resetn && reply != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL reply_unexpected reply=%b err=%b", reply, reply_err);
            end else begin
                m_e = exp_q.pop_front();
                if (reply !== onehot(m_e.ch) || reply_err !== m_e.err ||
                    rdata !== m_e.rd || clear_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reply got reply=%b err=%b rdata=%h busy=%b expected reply=%b err=%b rdata=%h busy=0",
                             reply, reply_err, rdata, clear_busy, onehot(m_e.ch), m_e.err, m_e.rd);
                end
            end
        end
    end

    // Monitor for the round-robin instance (grant order only)
    always @(negedge clk) begin
        if (resetn && b_reply != '0) begin
            checks++;
            if (b_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rr_unexpected reply=%b", b_reply);
            end else begin
                m_b = b_exp_q.pop_front();
                if (b_reply !== onehot(m_b) || b_reply_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_order got reply=%b err=%b expected reply=%b err=0",
                             b_reply, b_reply_err, onehot(m_b));
                end
            end
        end
    end

    task automatic raise(input int ch, input bit wr, input int addr, input logic [DW-1:0] d);
        if (wr) req_write[ch] = 1'b1;
        else    req_read[ch]  = 1'b1;
        req_addr[ch*AW +: AW]  = AW'(addr);
        req_wdata[ch*DW +: DW] = d;
    endtask

    task automatic wait_drop(input int ch, output int rcyc);
        int n = 0;
        while (reply[ch] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL timeout ch%0d no reply", ch);
        end
        rcyc          = cyc;
        req_read[ch]  = 1'b0;
        req_write[ch] = 1'b0;
    endtask

    task automatic single(input int ch, input bit wr, input int addr, input logic [DW-1:0] d);
        int t0, t1;
        @(negedge clk);
        push_exp(ch, wr, addr, d);
        raise(ch, wr, addr, d);
        t0 = cyc;
        wait_drop(ch, t1);
        checks++;
        if (t1 - t0 != 4) begin
            errors++;
            $display("FAIL latency ch%0d got %0d cycles expected 4", ch, t1 - t0);
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        if (reply !== '0 || reply_err !== 1'b0 || rdata !== '0 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s got reply=%b err=%b rdata=%h busy=%b expected all 0",
                     tag, reply, reply_err, rdata, clear_busy);
        end
    endtask

    function automatic int rand_addr();
        case ($urandom_range(0, 5))
            0:       return 2047;
            1:       return 2048;
            2:       return 4095;
            default: return int'($urandom_range(100, 131));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, a, b, lo, hi;
        resetn = 1'b0; clear_start = 1'b0; last_rd = '0;
        req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        b_req_read = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
        b_clear_start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        resetn = 1'b1;

        // Clear sweep: busy for exactly DEPTH cycles, held request served after
        single(0, 1'b1, 0, 31'd7);
        single(0, 1'b1, 2047, 31'd7);
        @(negedge clk);
        busy_cnt = 0;
        clear_start = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (100) @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        push_exp(2, 1'b0, 2047, '0);
        raise(2, 1'b0, 2047, '0);
        wait_drop(2, t1);
        checks++;
        if (busy_cnt != DEPTH) begin
            errors++;
            $display("FAIL clear_len got %0d cycles expected %0d", busy_cnt, DEPTH);
        end
        checks++;
        if (t1 <= last_busy_cyc) begin
            errors++;
            $display("FAIL clear_hold reply at %0d expected after %0d", t1, last_busy_cyc);
        end
        single(1, 1'b0, 0, '0);
        single(1, 1'b0, 2047, '0);

        // Basic write then read through another channel
        single(0, 1'b1, 5, 31'h155AA55A);
        single(1, 1'b0, 5, '0);

        // Out-of-range addresses
        single(3, 1'b1, 0, 31'h0ABCDEF1);
        single(2, 1'b1, 2048, 31'h7FFFFFFF);
        single(2, 1'b0, 2048, '0);
        single(3, 1'b0, 0, '0);

        // Fixed priority: ch1 before ch3, ch3 only after ch1 drops
        @(negedge clk);
        push_exp(1, 1'b0, 5, '0);
        push_exp(3, 1'b1, 9, 31'h1234_5678);
        raise(1, 1'b0, 5, '0);
        raise(3, 1'b1, 9, 31'h1234_5678);
        wait_drop(1, t1);
        wait_drop(3, t1);
        single(0, 1'b0, 9, '0);

        // Random traffic, single requests and simultaneous pairs
        for (int it = 0; it < 36; it++) begin
            if (it % 3 == 0) begin
                a = $urandom_range(0, N - 1);
                b = (a + $urandom_range(1, N - 1)) % N;
                lo = (a < b) ? a : b;
                hi = (a < b) ? b : a;
                @(negedge clk);
                begin
                    bit wl, wh;
                    int al, ah;
                    logic [DW-1:0] dl, dh;
                    wl = 1'($urandom_range(0, 1)); wh = 1'($urandom_range(0, 1));
                    al = rand_addr(); ah = rand_addr();
                    dl = DW'($urandom); dh = DW'($urandom);
                    push_exp(lo, wl, al, dl);
                    push_exp(hi, wh, ah, dh);
                    raise(lo, wl, al, dl);
                    raise(hi, wh, ah, dh);
                end
                wait_drop(lo, t1);
                wait_drop(hi, t1);
            end else begin
                single($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            end
        end

        // Reset during ACCESS: write aborted, outputs back to reset values
        single(2, 1'b0, 5, '0);
        @(negedge clk);
        raise(0, 1'b1, 5, 31'h0000_0BAD);
        @(negedge clk);
        resetn = 1'b0;
        req_write = '0;
        @(negedge clk);
        check_reset("reset_access");
        resetn = 1'b1;
        last_rd = '0;
        single(1, 1'b0, 5, '0);

        // Reset during CLEAR: sweep abandoned, upper words untouched
        single(3, 1'b1, 2047, 31'h0000_0777);
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (50) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset("reset_clear");
        resetn = 1'b1;
        last_rd = '0;
        for (int i = 0; i < 40; i++) model[i] = '0;
        single(0, 1'b1, 10, 31'h0246_8ACE);
        single(2, 1'b0, 10, '0);
        single(2, 1'b0, 2047, '0);
        single(1, 1'b0, 20, '0);

        // Round-robin instance: all channels reading continuously
        @(negedge clk);
        b_exp_q = '{0, 1, 2, 3, 0};
        b_req_read = '1;
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            int ch = 0;
            while (b_reply == '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL rr_timeout grant %0d missing", k);
            end
            for (int c = 0; c < N; c++) if (b_reply[c]) ch = c;
            b_req_read[ch] = 1'b0;
            @(negedge clk);
            b_req_read[ch] = 1'b1;
        end
        b_req_read = '0;
        repeat (10) @(negedge clk);

        checks++;
        if (exp_q.size() != 0 || b_exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d/%0d pending replies expected 0/0",
                     exp_q.size(), b_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
